// File: rtl/tx_addr_decoder.sv
// tx_addr_decoder: buffers host requests, decodes the target switch,
// waits out switch busy and issues a one-hot strobe or an error strobe.
module tx_addr_decoder #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int A_WIDTH     = 8,
  parameter int SPAN_LOG2   = 5,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wr,
  input  logic [A_WIDTH-1:0]     req_addr,
  input  logic [W_WIDTH-1:0]     req_data,
  input  logic [7:0]             req_op_id,
  input  logic [NUM_SW_INST-1:0] sw_busy,
  output logic [NUM_SW_INST-1:0] sel_en,
  output logic [7:0]             op_id,
  output logic [SPAN_LOG2-1:0]   sw_addr,
  output logic                   wr_en,
  output logic [W_WIDTH-1:0]     wr_data,
  output logic                   err_valid,
  output logic [1:0]             err_code,
  output logic [7:0]             err_op_id
);

  localparam int IW = A_WIDTH - SPAN_LOG2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_C   = CW'(TIMEOUT);

  typedef struct packed {
    logic               wr;
    logic [A_WIDTH-1:0] addr;
    logic [W_WIDTH-1:0] data;
    logic [7:0]         op;
  } req_t;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_WAIT, S_ISSUE, S_ERR
  } state_t;

  req_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          full, empty, push, pop;

  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);
  assign req_ready = ~full;
  assign push      = req_valid & ~full;

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= '{req_wr, req_addr,
                         req_data, req_op_id};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  state_t                 state_q, state_d;
  req_t                   cur_q, cur_d;
  logic [CW-1:0]          tmo_q, tmo_d;
  logic [NUM_SW_INST-1:0] sel_en_q, sel_en_d;
  logic [7:0]             op_id_q, op_id_d;
  logic [SPAN_LOG2-1:0]   sw_addr_q, sw_addr_d;
  logic                   wr_en_q, wr_en_d;
  logic [W_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                   err_valid_q, err_valid_d;
  logic [1:0]             err_code_q, err_code_d;
  logic [7:0]             err_op_q, err_op_d;
  logic [1:0]             ecode;

  logic [IW-1:0]          idx;
  logic [NUM_SW_INST-1:0] onehot;
  logic                   out_map, busy_hit;

  assign idx      = cur_q.addr[A_WIDTH-1:SPAN_LOG2];
  assign out_map  = 32'(idx) >= NUM_SW_INST;
  assign onehot   = NUM_SW_INST'(1) << idx;
  assign busy_hit = |(sw_busy & onehot);
  assign pop      = (state_q == S_ISSUE) |
                    (state_q == S_ERR);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    tmo_d       = tmo_q;
    ecode       = 2'b00;
    sel_en_d    = '0;
    op_id_d     = '0;
    sw_addr_d   = '0;
    wr_en_d     = 1'b0;
    wr_data_d   = '0;
    err_valid_d = 1'b0;
    err_code_d  = 2'b00;
    err_op_d    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d = S_DECODE;
          cur_d   = mem_q[rptr_q];
        end
      end
      S_DECODE: begin
        if (out_map) begin
          state_d = S_ERR;
          ecode   = 2'b01;
        end else if (busy_hit) begin
          state_d = S_WAIT;
          tmo_d   = CW'(1);
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (!busy_hit) begin
          state_d = S_ISSUE;
        end else if (tmo_q == TMO_C) begin
          state_d = S_ERR;
          ecode   = 2'b10;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // outputs are registered: load them on entry
    if (state_d == S_ISSUE) begin
      sel_en_d  = onehot;
      op_id_d   = cur_q.op;
      sw_addr_d = cur_q.addr[SPAN_LOG2-1:0];
      wr_en_d   = cur_q.wr;
      wr_data_d = cur_q.data;
    end
    if (state_d == S_ERR) begin
      err_valid_d = 1'b1;
      err_code_d  = ecode;
      err_op_d    = cur_q.op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      tmo_q       <= '0;
      sel_en_q    <= '0;
      op_id_q     <= '0;
      sw_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      err_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      tmo_q       <= tmo_d;
      sel_en_q    <= sel_en_d;
      op_id_q     <= op_id_d;
      sw_addr_q   <= sw_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_op_q    <= err_op_d;
    end
  end

  assign sel_en    = sel_en_q;
  assign op_id     = op_id_q;
  assign sw_addr   = sw_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_op_id = err_op_q;

endmodule
